// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, frame length, common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    WAIT_IDLE
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes and debounces one PS/2 line; emits one-cycle strobes on filtered edges.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are pulled high, so the filter starts from 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= ~sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain line control and done/error pulses.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned RTS_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_START,
  input  logic [7:0] TX_DATA,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  ps2_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_level, clk_fall, clk_rise;
  logic data_level, data_fall, data_rise;
  logic unused_strobes;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (CLK),
    .rst   (RST),
    .raw   (PS2_CLK_IN),
    .level (clk_level),
    .fall  (clk_fall),
    .rise  (clk_rise)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (CLK),
    .rst   (RST),
    .raw   (PS2_DATA_IN),
    .level (data_level),
    .fall  (data_fall),
    .rise  (data_rise)
  );

  assign unused_strobes = ^{clk_rise, data_fall, data_rise};

  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (TX_START) begin
          data_d   = TX_DATA;
          par_d    = odd_parity(TX_DATA);
          cnt_d    = '0;
          bit_d    = '0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RTS: begin
        if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
          cnt_d    = '0;
          bit_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (clk_fall) begin
          // bit_q counts falls already seen; this fall is bit n = bit_q + 1.
          bit_d = bit_q + 1'b1;
          if (bit_q < 4'd8) begin
            data_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else if (bit_q == 4'(PS2_FRAME_BITS - 2)) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = 1'b0;
            if (!data_level) begin
              state_d = WAIT_IDLE;
            end else begin
              clk_oe_d = 1'b0;
              busy_d   = 1'b0;
              err_d    = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end

      WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (clk_level && data_level) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND line model and a scaled-speed device model.
module tb_ps2_host_tx;

  localparam int unsigned INH   = 50;
  localparam int unsigned RTSC  = 16;
  localparam int unsigned TO    = 2000;
  localparam int unsigned FLEN  = 4;
  localparam int          H     = 40;
  localparam int          WMAX  = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       busy, done, err, clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_at_pulse = 0;

  assign clk_line  = dev_clk & ~clk_oe;
  assign data_line = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .TX_START    (tx_start),
    .TX_DATA     (tx_data),
    .TX_BUSY     (busy),
    .TX_DONE     (done),
    .TX_ERR      (err),
    .PS2_CLK_IN  (clk_line),
    .PS2_DATA_IN (data_line),
    .PS2_CLK_OE  (clk_oe),
    .PS2_DATA_OE (data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if ((done || err) && busy) busy_at_pulse++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // 1 = done, 2 = err, 0 = neither within the budget
  task automatic wait_end(output int kind);
    kind = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin kind = 1; break; end
      if (err) begin kind = 2; break; end
      @(negedge clk);
    end
  endtask

  // Device side: samples data at each clock rise (the release rise carries the start bit).
  task automatic dev_frame(input bit ack, input bit glitch, input int abort_after,
                           output logic [10:0] seen, output bit ok);
    int w;
    ok = 1'b0;
    seen = '0;
    w = 0;
    while (!(clk_oe == 1'b0 && data_oe == 1'b1) && w < WMAX) begin
      @(negedge clk);
      w++;
    end
    if (w >= WMAX) return;
    ok = 1'b1;
    repeat (H) @(negedge clk);
    seen[0] = data_line;
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      if (i == abort_after) begin
        repeat (FLEN + 6) @(negedge clk);
        return;
      end
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) seen[i] = data_line;
      if (i == 10) begin
        repeat (H / 2) @(negedge clk);
        if (ack) dev_data = 1'b0;
        repeat (H / 2) @(negedge clk);
      end else if (i == 11) begin
        repeat (H / 2) @(negedge clk);
        dev_data = 1'b1;
      end else if (glitch) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - 13) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset_clk_oe: got %b want 0", clk_oe); end
    vectors++; if (data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
  endtask

  task automatic test_send_ed();
    logic [10:0] seen;
    bit ok;
    int kind, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ed_busy_rise: got %b want 1", busy); end
    vectors++; if (clk_oe !== 1'b1) begin miscompares++; $display("FAIL ed_clk_oe_rise: got %b want 1", clk_oe); end
    dev_frame(1'b1, 1'b0, 0, seen, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ed_release: got %b want 1", ok); end
    // stop 1, parity 1, ED lsb-first, start 0
    vectors++; if (seen !== 11'b1_1_11101101_0) begin miscompares++; $display("FAIL ed_frame: got %b want %b", seen, 11'b1_1_11101101_0); end
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL ed_end: got %0d want 1", kind); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ed_busy_fall: got %b want 0", busy); end
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL ed_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL ed_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_send_f4();
    logic [10:0] seen;
    bit ok;
    int kind, c1, c2;
    start_tx(8'hF4);
    c1 = 0; c2 = 0;
    while (clk_oe === 1'b1 && data_oe === 1'b0 && c1 < 1000) begin c1++; @(negedge clk); end
    while (clk_oe === 1'b1 && data_oe === 1'b1 && c2 < 1000) begin c2++; @(negedge clk); end
    vectors++; if (c1 !== INH) begin miscompares++; $display("FAIL f4_inhibit_len: got %0d want %0d", c1, INH); end
    vectors++; if (c2 !== RTSC) begin miscompares++; $display("FAIL f4_rts_len: got %0d want %0d", c2, RTSC); end
    dev_frame(1'b1, 1'b0, 0, seen, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL f4_release: got %b want 1", ok); end
    vectors++; if (seen !== 11'b1_0_11110100_0) begin miscompares++; $display("FAIL f4_frame: got %b want %b", seen, 11'b1_0_11110100_0); end
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL f4_end: got %0d want 1", kind); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_no_ack();
    logic [10:0] seen;
    bit ok;
    int kind, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    dev_frame(1'b0, 1'b0, 0, seen, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL noack_release: got %b want 1", ok); end
    wait_end(kind);
    repeat (20) @(negedge clk);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL noack_err_count: got %0d want 1", err_cnt - e0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL noack_done_count: got %0d want 0", done_cnt - d0); end
    vectors++; if ({clk_oe, data_oe, busy} !== 3'b000) begin miscompares++; $display("FAIL noack_released: got %b want 000", {clk_oe, data_oe, busy}); end
  endtask

  task automatic test_timeout();
    int n, w, d0;
    d0 = done_cnt;
    start_tx(8'hED);
    w = 0;
    while (clk_oe === 1'b1 && w < WMAX) begin @(negedge clk); w++; end
    n = 0;
    while (err !== 1'b1 && n < int'(TO) + 100) begin @(negedge clk); n++; end
    vectors++; if (n !== TO) begin miscompares++; $display("FAIL timeout_len: got %0d want %0d", n, TO); end
    vectors++; if ({clk_oe, data_oe, busy} !== 3'b000) begin miscompares++; $display("FAIL timeout_released: got %b want 000", {clk_oe, data_oe, busy}); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] seen;
    bit ok;
    int kind, d0, e0;
    start_tx(8'hED);
    dev_frame(1'b1, 1'b0, 5, seen, ok);
    vectors++; if (data_oe !== 1'b1) begin miscompares++; $display("FAIL rstmid_bit4_drive: got %b want 1", data_oe); end
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({clk_oe, data_oe} !== 2'b00) begin miscompares++; $display("FAIL rstmid_oe: got %b want 00", {clk_oe, data_oe}); end
    dev_clk = 1'b1;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    vectors++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin miscompares++; $display("FAIL rstmid_pulses: got %0d want 0", (done_cnt - d0) + (err_cnt - e0)); end
    start_tx(8'hFF);
    dev_frame(1'b1, 1'b0, 0, seen, ok);
    vectors++; if (seen !== 11'b1_1_11111111_0) begin miscompares++; $display("FAIL rstmid_ff_frame: got %b want %b", seen, 11'b1_1_11111111_0); end
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL rstmid_ff_end: got %0d want 1", kind); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch_and_ignored_start();
    logic [10:0] seen;
    bit ok;
    int kind;
    start_tx(8'hF4);
    fork
      dev_frame(1'b1, 1'b1, 0, seen, ok);
      begin
        repeat (300) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    vectors++; if (seen !== 11'b1_0_11110100_0) begin miscompares++; $display("FAIL glitch_frame: got %b want %b", seen, 11'b1_0_11110100_0); end
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL glitch_end: got %0d want 1", kind); end
    repeat (200) @(negedge clk);
    vectors++; if ({busy, clk_oe} !== 2'b00) begin miscompares++; $display("FAIL glitch_no_queue: got %b want 00", {busy, clk_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seen;
    bit ok;
    int kind;
    start_tx(8'hF4);
    dev_frame(1'b1, 1'b0, 0, seen, ok);
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL b2b_first_end: got %0d want 1", kind); end
    start_tx(8'hED);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got %b want 1", busy); end
    dev_frame(1'b1, 1'b0, 0, seen, ok);
    vectors++; if (seen !== 11'b1_1_11101101_0) begin miscompares++; $display("FAIL b2b_frame: got %b want %b", seen, 11'b1_1_11101101_0); end
    wait_end(kind);
    vectors++; if (kind !== 1) begin miscompares++; $display("FAIL b2b_second_end: got %0d want 1", kind); end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_send_ed();
    test_send_f4();
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_glitch_and_ignored_start();
    test_back_to_back();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    vectors++; if (busy_at_pulse !== 0) begin miscompares++; $display("FAIL pulse_with_busy: got %0d want 0", busy_at_pulse); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
